// File: rtl/tile_skew_reader.sv
// Tile FIFO read side: pops one SIZE x SIZE tile and streams it to the array as a skewed wavefront.
// Latency: pop cycle to first lane-0 valid is 2 cycles; a tile streams over 2*SIZE-1 unstalled steps.
// Backpressure: stall freezes the step counter and drops all lane valids; pop only when pop_rdy is high.
module tile_skew_reader #(
    parameter int SIZE  = 2,
    parameter int WIDTH = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  pop_rdy,
    output logic                                  pop,
    input  logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0]  tile_in,
    input  logic                                  stall,
    output logic [SIZE-1:0][WIDTH-1:0]            a_out,
    output logic [SIZE-1:0]                       a_vld,
    output logic                                  busy,
    output logic                                  tile_done
);

    localparam int TW = $clog2(2*SIZE-1);
    localparam int KW = $clog2(SIZE);
    localparam logic [TW-1:0] T_LAST = TW'(2*SIZE-2);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WAIT   = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;

    logic [1:0]                          state_q, state_d;
    logic [TW-1:0]                       t_q, t_d;
    logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0] buf_q, buf_d;

    // Stream step is "final" only when it actually advances (not stalled).
    logic last_step;
    assign last_step = (state_q == STREAM) && !stall && (t_q == T_LAST);

    // Next-state: pop in IDLE or on the final step, capture in WAIT, walk t during STREAM.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                t_d = '0;
                if (pop_rdy) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // FIFO dout is valid this cycle; stall does not block the capture.
                buf_d   = tile_in;
                t_d     = '0;
                state_d = STREAM;
            end
            STREAM: begin
                if (!stall) begin
                    if (t_q == T_LAST) begin
                        t_d     = '0;
                        state_d = pop_rdy ? WAIT : IDLE;
                    end else begin
                        t_d = t_q + TW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                t_d     = '0;
            end
        endcase
    end

    // State, step counter and tile buffer; reset discards any in-flight tile.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            buf_q   <= buf_d;
        end
    end

    // Outputs: lane r shows column t-r of its row while that column is in range.
    always_comb begin
        pop       = 1'b0;
        a_out     = '0;
        a_vld     = '0;
        tile_done = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                // A reset cycle must not pull a tile the block is about to forget.
                pop = pop_rdy && !rst;
            end
            STREAM: begin
                for (int r = 0; r < SIZE; r++) begin
                    if ((int'(t_q) >= r) && ((int'(t_q) - r) < SIZE)) begin
                        a_out[r] = buf_q[r][KW'(int'(t_q) - r)];
                        a_vld[r] = !stall;
                    end
                end
                if (last_step) begin
                    tile_done = 1'b1;
                    pop       = pop_rdy && !rst;
                end
            end
            default: begin
                pop = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_tile_skew_reader.sv
// Bench for tile_skew_reader: SIZE=2 and SIZE=4 instances fed by a simple tile FIFO model.
// Latency: checks follow the cycle-by-cycle schedule of each directed scenario.
// Backpressure: exercises global stall and pop_rdy gating of pops.
module tb_tile_skew_reader;

    typedef logic [1:0][1:0][7:0] tile2_t;
    typedef logic [3:0][3:0][7:0] tile4_t;

    logic        clk;
    logic        rst;

    logic        pop_rdy, pop, stall, busy, tile_done;
    tile2_t      tile_in;
    logic [1:0][7:0] a_out;
    logic [1:0]  a_vld;

    logic        pop_rdy4, pop4, stall4, busy4, done4;
    tile4_t      tile_in4;
    logic [3:0][7:0] a_out4;
    logic [3:0]  a_vld4;

    tile2_t      fifo [0:7];
    int          f_n, f_rd;
    tile4_t      tile4;
    int          f4_n, f4_rd;

    int          n_checks, n_fail;

    logic [15:0] ao_e;
    logic [1:0]  v_e;

    tile_skew_reader #(.SIZE(2), .WIDTH(8)) u_dut2 (
        .clk(clk), .rst(rst), .pop_rdy(pop_rdy), .pop(pop), .tile_in(tile_in),
        .stall(stall), .a_out(a_out), .a_vld(a_vld), .busy(busy), .tile_done(tile_done)
    );

    tile_skew_reader #(.SIZE(4), .WIDTH(8)) u_dut4 (
        .clk(clk), .rst(rst), .pop_rdy(pop_rdy4), .pop(pop4), .tile_in(tile_in4),
        .stall(stall4), .a_out(a_out4), .a_vld(a_vld4), .busy(busy4), .tile_done(done4)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // All SIZE=2 outputs for one cycle.
    task automatic chk2(input string tag, input logic p, input logic [1:0] v,
                        input logic [15:0] ao, input logic b, input logic d);
        check_eq({tag, ".pop"},  32'(pop), 32'(p));
        check_eq({tag, ".vld"},  32'(a_vld), 32'(v));
        check_eq({tag, ".aout"}, 32'(a_out), 32'(ao));
        check_eq({tag, ".busy"}, 32'(busy), 32'(b));
        check_eq({tag, ".done"}, 32'(tile_done), 32'(d));
    endtask

    function automatic logic [15:0] lanes2(input int l0, input int l1);
        return {8'(l1), 8'(l0)};
    endfunction

    function automatic tile2_t mk2(input int a, input int b, input int c, input int d);
        tile2_t t;
        t[0][0] = 8'(a); t[0][1] = 8'(b);
        t[1][0] = 8'(c); t[1][1] = 8'(d);
        return t;
    endfunction

    // One clock: FIFO model delivers dout the cycle after a sampled pop.
    task automatic tick();
        logic p2, p4;
        p2 = pop;
        p4 = pop4;
        @(posedge clk);
        #1;
        if (p2 === 1'b1) begin
            tile_in = fifo[f_rd];
            f_rd++;
        end
        if (p4 === 1'b1) begin
            tile_in4 = tile4;
            f4_rd++;
        end
        pop_rdy  = (f_rd < f_n);
        pop_rdy4 = (f4_rd < f4_n);
        #1;
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1;
        pop_rdy = 1'b0; stall = 1'b0; tile_in = '0;
        pop_rdy4 = 1'b0; stall4 = 1'b0; tile_in4 = '0;
        f_n = 0; f_rd = 0; f4_n = 0; f4_rd = 0;
        n_checks = 0; n_fail = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                tile4[r][c] = 8'(16*r + c);

        // Reset held two cycles with the FIFO empty.
        tick(); tick();
        chk2("rst", 1'b0, 2'b00, 16'h0, 1'b0, 1'b0);
        check_eq("rst4.busy", 32'(busy4), 32'd0);
        check_eq("rst4.vld", 32'(a_vld4), 32'd0);
        rst = 1'b0;
        #1;
        chk2("idle", 1'b0, 2'b00, 16'h0, 1'b0, 1'b0);

        // Single tile.
        fifo[0] = mk2(11, 12, 21, 22); f_n = 1; pop_rdy = 1'b1; #1;
        chk2("s.c0", 1'b1, 2'b00, 16'h0, 1'b0, 1'b0); tick();
        chk2("s.c1", 1'b0, 2'b00, 16'h0, 1'b1, 1'b0); tick();
        chk2("s.c2", 1'b0, 2'b01, lanes2(11, 0), 1'b1, 1'b0); tick();
        chk2("s.c3", 1'b0, 2'b11, lanes2(12, 21), 1'b1, 1'b0); tick();
        chk2("s.c4", 1'b0, 2'b10, lanes2(0, 22), 1'b1, 1'b1); tick();
        chk2("s.c5", 1'b0, 2'b00, 16'h0, 1'b0, 1'b0);

        // Back-to-back: three tiles, elements 10*(j+1) + 1 + 2*row + col.
        fifo[1] = mk2(11, 12, 13, 14);
        fifo[2] = mk2(21, 22, 23, 24);
        fifo[3] = mk2(31, 32, 33, 34);
        f_n = 4; pop_rdy = 1'b1; #1;
        for (int c = 0; c < 14; c++) begin
            ao_e = '0; v_e = '0;
            if (c >= 2 && c <= 12 && ((c - 2) % 4) <= 2) begin
                for (int r = 0; r < 2; r++) begin
                    int s, k, j;
                    j = (c - 2) / 4;
                    s = (c - 2) % 4;
                    k = s - r;
                    if (k >= 0 && k < 2) begin
                        v_e[r] = 1'b1;
                        ao_e[r*8 +: 8] = 8'(10*(j+1) + 1 + 2*r + k);
                    end
                end
            end
            chk2($sformatf("b2b.c%0d", c), (c == 0 || c == 4 || c == 8), v_e, ao_e,
                 (c >= 1 && c <= 12), (c == 4 || c == 8 || c == 12));
            tick();
        end

        // Stall at step t=1 for two cycles.
        fifo[4] = mk2(11, 12, 21, 22); f_n = 5; pop_rdy = 1'b1; #1;
        chk2("st.c0", 1'b1, 2'b00, 16'h0, 1'b0, 1'b0); tick();
        tick();
        chk2("st.c2", 1'b0, 2'b01, lanes2(11, 0), 1'b1, 1'b0); tick();
        stall = 1'b1; #1;
        chk2("st.c3", 1'b0, 2'b00, lanes2(12, 21), 1'b1, 1'b0); tick();
        chk2("st.c4", 1'b0, 2'b00, lanes2(12, 21), 1'b1, 1'b0);
        tick();
        stall = 1'b0; #1;
        chk2("st.c5", 1'b0, 2'b11, lanes2(12, 21), 1'b1, 1'b0); tick();
        chk2("st.c6", 1'b0, 2'b10, lanes2(0, 22), 1'b1, 1'b1); tick();
        chk2("st.c7", 1'b0, 2'b00, 16'h0, 1'b0, 1'b0);

        // Reset mid-stream with a second tile waiting.
        fifo[5] = mk2(1, 2, 3, 4); fifo[6] = mk2(5, 6, 7, 8);
        f_n = 7; pop_rdy = 1'b1; #1;
        check_eq("rm.pop0", 32'(pop), 32'd1);
        tick(); tick(); tick();
        chk2("rm.t1", 1'b0, 2'b11, lanes2(2, 3), 1'b1, 1'b0);
        rst = 1'b1; #1;
        tick();
        chk2("rm.inrst", 1'b0, 2'b00, 16'h0, 1'b0, 1'b0);
        rst = 1'b0; #1;
        chk2("rm.after", 1'b1, 2'b00, 16'h0, 1'b0, 1'b0); tick();
        chk2("rm.wait", 1'b0, 2'b00, 16'h0, 1'b1, 1'b0); tick();
        chk2("rm.t0", 1'b0, 2'b01, lanes2(5, 0), 1'b1, 1'b0); tick();
        chk2("rm.t1b", 1'b0, 2'b11, lanes2(6, 7), 1'b1, 1'b0); tick();
        chk2("rm.t2", 1'b0, 2'b10, lanes2(0, 8), 1'b1, 1'b1); tick();
        chk2("rm.end", 1'b0, 2'b00, 16'h0, 1'b0, 1'b0);

        // SIZE=4 wavefront, buf[r][c] = 16*r + c.
        f4_n = 1; pop_rdy4 = 1'b1; #1;
        check_eq("s4.pop", 32'(pop4), 32'd1); tick();
        check_eq("s4.wait", 32'(busy4), 32'd1); tick();
        check_eq("s4.t0.vld", 32'(a_vld4), 32'h1);
        tick(); tick(); tick();
        check_eq("s4.t3.vld", 32'(a_vld4), 32'hf);
        check_eq("s4.t3.aout", 32'(a_out4), 32'h30211203);
        check_eq("s4.t3.done", 32'(done4), 32'd0);
        tick(); tick(); tick();
        check_eq("s4.t6.vld", 32'(a_vld4), 32'h8);
        check_eq("s4.t6.aout", 32'(a_out4), 32'h33000000);
        check_eq("s4.t6.done", 32'(done4), 32'd1);
        check_eq("s4.t6.pop", 32'(pop4), 32'd0);
        tick();
        check_eq("s4.idle", 32'(busy4), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
